popcount_seq_ctrl: RTL
======================

Name: popcount_seq_ctrl

Overview:
Sequencer that computes the population count of a WORD_W-bit word by time-multiplexing one external 8-bit ones-counter datapath. It accepts a word on a valid/ready input channel and presents successive 8-bit slices to the counter, LSB slice first. It accumulates the returned per-slice counts and delivers the total on a valid/ready output channel. It sits between a word producer and the 8-bit ones-counter, which is instantiated alongside it at the next level up.

Parameters:
WORD_W, 32, input word width. Must be a multiple of 8 and at least 8. Any other value is an elaboration error.
EARLY_EXIT, 1, when 1, the scan stops as soon as all slices above the current one are zero.
Derived: NSLICE = WORD_W/8. CW = clog2(WORD_W+1).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  producer has a word.
in_ready  out  1  block can accept a word.
in_data  in  WORD_W  word to count.
slice_en  out  1  slice_data is being consumed this cycle.
slice_data  out  8  current slice driven to the ones-counter.
slice_cnt  in  4  ones-counter result for slice_data, combinational, valid in the same cycle, range 0..8.
out_valid  out  1  out_count is valid.
out_ready  in  1  consumer accepts the result.
out_count  out  CW  total ones in the accepted word.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: on rst high at a clock edge, go to IDLE.
  - in_ready=1, out_valid=0, slice_en=0, busy=0.
  - out_count=0, slice_data=0, internal accumulator=0, index=0, word register=0.
  - rst takes priority over every other event, including in mid-RUN and in DONE. Any in-flight result is discarded and no out_valid is issued for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; all other outputs are held at reset values except out_count, which holds its last value.
  - On in_valid & in_ready: latch in_data, clear the accumulator, set index=0, go to RUN.
- RUN (in_ready=0, busy=1, slice_en=1):
  - slice_data = word[index*8 +: 8], combinational from registers.
  - At each edge: accumulator += slice_cnt, zero-extended to CW bits. The accumulator cannot overflow because its maximum is WORD_W.
  - Go to DONE when index == NSLICE-1, or when EARLY_EXIT=1 and word bits above slice index are all zero. Otherwise index increments.
  - On the exit edge, out_count is loaded with accumulator + slice_cnt.
- DONE (slice_en=0, busy=1, in_ready=0):
  - out_valid=1. out_count is stable until transfer.
  - On out_ready=1: go to IDLE, and out_valid drops the next cycle.
  - out_ready held low keeps the block in DONE indefinitely.
  - The block does not look at out_ready outside DONE.
- Input changes while busy: in_data and in_valid are ignored; the latched word governs the scan.
- Latency: handshake at cycle T gives RUN cycles T+1..T+k and out_valid=1 from cycle T+k+1.
  - k = NSLICE when EARLY_EXIT=0.
  - k = 1 + index of the highest nonzero slice when EARLY_EXIT=1, with k=1 for an all-zero word.
- Throughput: with out_ready tied high, the minimum spacing between accepted words is k+2 cycles, since in_ready returns the cycle after the DONE transfer. There is no input/output overlap.
- slice_data = 0 whenever slice_en = 0.
- Word width WORD_W=8 (NSLICE=1): RUN lasts exactly one cycle.

Test Plan:
1. WORD_W=32, EARLY_EXIT=0. Accept 0xFFFFFFFF at T, out_ready=1 → slice_en high T+1..T+4, slice_data=0xFF each cycle, out_count=32 with out_valid at T+5, in_ready=1 at T+6.
2. EARLY_EXIT=1. Accept 0x000000FF → one RUN cycle, out_count=8 at T+2. Accept 0x00000000 → out_count=0 at T+2. Accept 0x80000001 → 4 RUN cycles, out_count=2 at T+5.
3. Backpressure: 0x0F0F0F0F with out_ready low for 3 cycles after out_valid → out_count=16 held stable, in_ready=0 and busy=1 throughout. Transfer on the 4th cycle.
4. Input churn during RUN: in_valid=1 with changing in_data while busy → ignored. Result matches the latched word: 0x12345678 → 13.
5. Reset mid-operation: assert rst at the 2nd RUN cycle of 0xFFFFFFFF → next cycle IDLE, in_ready=1, out_count=0, no out_valid. A following 0x00000003 → 2.
6. Back-to-back: two words offered continuously with out_ready=1 and EARLY_EXIT=0 → acceptances exactly 6 cycles apart, counts correct in order.

Source files
------------

// File: rtl/popcount_seq_ctrl.sv
// popcount_seq_ctrl
//   Counts the ones in a WORD_W-bit word by feeding its 8-bit slices, LSB
//   slice first, through one external combinational 8-bit ones-counter and
//   summing the per-slice results.
// Ports
//   clk, rst               : single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data : word input channel (valid/ready)
//   slice_en/slice_data    : slice presented to the ones-counter (zero when idle)
//   slice_cnt              : ones-counter result for slice_data, same cycle
//   out_valid/out_ready/out_count : result channel (valid/ready)
//   busy                   : high while scanning or holding a result
module popcount_seq_ctrl #(
  parameter int WORD_W     = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            in_data,
  output logic                         slice_en,
  output logic [7:0]                   slice_data,
  input  logic [3:0]                   slice_cnt,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WORD_W+1)-1:0]  out_count,
  output logic                         busy
);
  localparam int NSLICE = WORD_W / 8;
  localparam int CW     = $clog2(WORD_W + 1);
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (WORD_W < 8 || (WORD_W % 8) != 0) begin : g_bad_width
      $error("popcount_seq_ctrl: WORD_W must be a multiple of 8 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     out_count_q, out_count_d;

  logic [NSLICE-1:0] slice_nz;
  logic [7:0]        cur_slice;
  logic              upper_zero;
  logic              last_slice;
  logic [CW-1:0]     sum;

  // Per-slice nonzero flags and the slice selected by the index.
  always_comb begin
    cur_slice = 8'h00;
    for (int j = 0; j < NSLICE; j++) begin
      slice_nz[j] = |word_q[j*8 +: 8];
      if (idx_q == IW'(j)) cur_slice = word_q[j*8 +: 8];
    end
  end

  // True when every slice above the current index is zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NSLICE; j++)
      if (j > int'(idx_q) && slice_nz[j]) upper_zero = 1'b0;
  end

  assign last_slice = (idx_q == IW'(NSLICE - 1)) || (EARLY_EXIT && upper_zero);
  assign sum        = acc_q + CW'(slice_cnt);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_count_d = out_count_q;
    in_ready    = 1'b0;
    slice_en    = 1'b0;
    slice_data  = 8'h00;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        slice_en   = 1'b1;
        slice_data = cur_slice;
        acc_d      = sum;
        if (last_slice) begin
          out_count_d = sum;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_count = out_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
    end
  end
endmodule
